// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART transmitter among NUM_REQ
//            byte producers. One byte is accepted per grant and launched with
//            a single-cycle tx_start pulse. No further grant is made until the
//            transmitter reports tx_done, or until a watchdog aborts the frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NUM_REQ        - number of requesters (2..8)
//   TIMEOUT_CYCLES - cycles from the LAUNCH edge to a watchdog abort
// Ports:
//   clk         in   clock, all logic on the rising edge
//   rst_n       in   asynchronous active-low reset
//   req         in   [NUM_REQ]    requester i has a byte pending
//   req_data    in   [8*NUM_REQ]  byte of requester i on [8i+7:8i]
//   req_last    in   [NUM_REQ]    byte of requester i ends its packet
//   ack         out  [NUM_REQ]    one-cycle pulse, byte of requester i taken
//   tx_start    out  one-cycle pulse, transmitter loads tx_data
//   tx_data     out  [8] byte to transmit, held until the frame ends
//   tx_busy     in   transmitter occupied, blocks new grants
//   tx_done     in   one-cycle pulse at the end of the stop bit
//   grant_id    out  [clog2(NUM_REQ)] index of the current/last winner
//   active      out  high in every state except IDLE
//   err_timeout out  one-cycle pulse on watchdog abort
// Build option:
//   UART_ARB_LOCK_EN - when defined, a requester keeps the arbiter until the
//                      byte flagged with req_last has been launched.
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err_timeout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [WDW-1:0] c_WDOG_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0] c_LAST_INIT = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_last_grant;
  logic [WDW-1:0]   r_wdog;

  logic [NUM_REQ-1:0] w_req_elig;
  logic               w_found;
  logic [IDW-1:0]     w_winner;
  logic [7:0]         w_win_data;
  int                 w_pos;

`ifdef UART_ARB_LOCK_EN
  logic           r_locked;
  logic [IDW-1:0] r_lock_id;

  // While a packet is open only its owner may be granted, even if it has
  // momentarily dropped req; everyone else simply waits.
  always_comb begin
    w_req_elig = req;
    if (r_locked) begin
      w_req_elig = req & (NUM_REQ'(1) << r_lock_id);
    end
  end
`else
  logic w_unused_req_last;

  assign w_req_elig        = req;
  assign w_unused_req_last = ^req_last;
`endif

  // Rotating priority search starting just above the last winner. The loop
  // runs from the farthest offset down to the nearest so that the nearest
  // pending requester is the final (winning) assignment.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_pos    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = (int'(r_last_grant) + 1 + k) % NUM_REQ;
      if (w_req_elig[IDW'(w_pos)]) begin
        w_found  = 1'b1;
        w_winner = IDW'(w_pos);
      end
    end
  end

  // Byte lane of the selected requester.
  always_comb begin
    w_win_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == w_winner) begin
        w_win_data = req_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= c_LAST_INIT;
      r_wdog       <= '0;
      ack          <= '0;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      grant_id     <= '0;
      active       <= 1'b0;
      err_timeout  <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      r_locked     <= 1'b0;
      r_lock_id    <= '0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      ack         <= '0;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_found && !tx_busy) begin
            tx_data  <= w_win_data;
            grant_id <= w_winner;
            ack      <= NUM_REQ'(1) << w_winner;
            active   <= 1'b1;
            r_state  <= ST_LAUNCH;
`ifdef UART_ARB_LOCK_EN
            r_locked  <= ~req_last[w_winner];
            r_lock_id <= w_winner;
`endif
          end
        end

        ST_LAUNCH: begin
          tx_start <= 1'b1;
          r_wdog   <= '0;
          r_state  <= ST_WAIT_DONE;
        end

        ST_WAIT_DONE: begin
          // Completion is checked first so that a tx_done landing on the
          // final watchdog cycle is treated as a normal finish.
          if (tx_done) begin
            r_last_grant <= grant_id;
            active       <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (r_wdog == c_WDOG_LAST) begin
            err_timeout  <= 1'b1;
            r_last_grant <= grant_id;
            active       <= 1'b0;
            r_state      <= ST_IDLE;
`ifdef UART_ARB_LOCK_EN
            r_locked     <= 1'b0;
`endif
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end

        default: begin
          active  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
